// File: rtl/cu_memcpy_multi_channel_control_if.sv
// Channel-side bus between the memcpy control unit and its per-channel read/write engines.
// master: the control unit (drives engine enables, receives completion pulses).
// slave : the engine side (receives enables, returns single-cycle completion pulses).
//   read_done_pulse / write_done_pulse : per-channel completion pulses
//   chan_read_enable / chan_write_enable : per-channel engine enables
//   prefetch_read_enable / prefetch_write_enable : prefetch stream enables
interface cu_memcpy_multi_channel_control_if #(
    parameter int unsigned NUM_CHANNELS = 4
) ();
    logic [NUM_CHANNELS-1:0] read_done_pulse;
    logic [NUM_CHANNELS-1:0] write_done_pulse;
    logic [NUM_CHANNELS-1:0] chan_read_enable;
    logic [NUM_CHANNELS-1:0] chan_write_enable;
    logic                    prefetch_read_enable;
    logic                    prefetch_write_enable;

    modport master (
        input  read_done_pulse,
        input  write_done_pulse,
        output chan_read_enable,
        output chan_write_enable,
        output prefetch_read_enable,
        output prefetch_write_enable
    );

    modport slave (
        output read_done_pulse,
        output write_done_pulse,
        input  chan_read_enable,
        input  chan_write_enable,
        input  prefetch_read_enable,
        input  prefetch_write_enable
    );
endinterface

// File: rtl/cu_memcpy_multi_channel_control.sv
// Multi-channel memcpy control unit. Sequences NUM_CHANNELS copy channels from one WED job,
// aggregates per-channel completion pulses into saturating job counters, flags job completion
// per mode and derives TLB sizing from the latched mode word.
// Ports:
//   clock, rstn_in (async active-low), enabled_in (low freezes everything)
//   wed_valid, size_send, size_recive : job request and expected cache-line counts
//   cfg_var1/3/4 : config words, zero means "no update"
//   chan_bus (master) : per-channel enables and completion pulses
//   tlb_size, max_tlb_cl_requests : derived sizing, minus one
//   read/write_job_counter_done, cu_return_var1/2, cu_done, cu_status, cu_state : job status
module cu_memcpy_multi_channel_control #(
    parameter int unsigned NUM_CHANNELS        = 4,
    parameter int unsigned COUNT_BITS          = 32,
    parameter int unsigned TLB_SIZE            = 64,
    parameter int unsigned MAX_TLB_CL_REQUESTS = 64
) (
    input  logic                  clock,
    input  logic                  rstn_in,
    input  logic                  enabled_in,
    input  logic                  wed_valid,
    input  logic [COUNT_BITS-1:0] size_send,
    input  logic [COUNT_BITS-1:0] size_recive,
    input  logic [63:0]           cfg_var1,
    input  logic [63:0]           cfg_var3,
    input  logic [63:0]           cfg_var4,
    cu_memcpy_multi_channel_control_if.master chan_bus,
    output logic [63:0]           tlb_size,
    output logic [63:0]           max_tlb_cl_requests,
    output logic [COUNT_BITS-1:0] read_job_counter_done,
    output logic [COUNT_BITS-1:0] write_job_counter_done,
    output logic [63:0]           cu_return_var1,
    output logic [63:0]           cu_return_var2,
    output logic                  cu_done,
    output logic [63:0]           cu_status,
    output logic [1:0]            cu_state
);
    typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StRun = 2'd2, StDone = 2'd3} state_e;

    // Config word bits are numbered MSB-first: bit n of the mode word lives at index 63-n.
    localparam int unsigned IdxRd   = 63 - 23;
    localparam int unsigned IdxWr22 = 63 - 22;
    localparam int unsigned IdxWr21 = 63 - 21;
    localparam int unsigned IdxPfr  = 63 - 30;
    localparam int unsigned IdxPfw  = 63 - 31;
    localparam int unsigned IdxDir  = 63 - 39;

    logic                    rstn_q;
    state_e                  state_q;
    logic [63:0]             cfg1_q, cfg3_q, cfg4_q;
    logic [COUNT_BITS-1:0]   size_send_q, size_recv_q, rd_cnt_q, wr_cnt_q;
    logic [NUM_CHANNELS-1:0] rd_en_q, wr_en_q;
    logic                    pfr_en_q, pfw_en_q, done_q;
    logic [63:0]             ret1_q, ret2_q, tlb_q, max_q;

    logic                    mode_rd, mode_wr, mode_pfr, mode_pfw, mode_dir, rd_only;
    logic [3:0]              mode_sh;
    logic [NUM_CHANNELS-1:0] raw_mask, act_mask, rd_en_d, wr_en_d;
    logic [COUNT_BITS-1:0]   rd_cnt_d, wr_cnt_d;
    logic                    done_cond;

    function automatic logic [COUNT_BITS:0] popcount(input logic [NUM_CHANNELS-1:0] v);
        logic [COUNT_BITS:0] n;
        n = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) n = n + {{COUNT_BITS{1'b0}}, v[i]};
        return n;
    endfunction

    function automatic logic [COUNT_BITS-1:0] sat_add(input logic [COUNT_BITS-1:0] cnt,
                                                       input logic [COUNT_BITS:0]   inc,
                                                       input logic [COUNT_BITS-1:0] lim);
        logic [COUNT_BITS:0] sum;
        sum = {1'b0, cnt} + inc;
        return (sum > {1'b0, lim}) ? lim : sum[COUNT_BITS-1:0];
    endfunction

    always_comb begin
        mode_rd  = cfg1_q[IdxRd];
        mode_wr  = cfg1_q[IdxWr21] | cfg1_q[IdxWr22];
        mode_pfr = cfg1_q[IdxPfr];
        mode_pfw = cfg1_q[IdxPfw];
        mode_dir = cfg1_q[IdxDir];
        mode_sh  = cfg1_q[31:28];                  // bits 32..35, bit 32 is the MSB
        raw_mask = cfg1_q[23 -: NUM_CHANNELS];     // bit 40 is the MSB of the mask
        act_mask = (raw_mask == '0) ? '1 : raw_mask;
        rd_only  = mode_rd & ~mode_wr;
        rd_en_d  = act_mask & {NUM_CHANNELS{mode_rd}};
        wr_en_d  = act_mask & {NUM_CHANNELS{mode_wr}};
        rd_cnt_d = sat_add(rd_cnt_q, popcount(chan_bus.read_done_pulse & act_mask), size_send_q);
        wr_cnt_d = sat_add(wr_cnt_q, popcount(chan_bus.write_done_pulse & act_mask), size_recv_q);
        if (rd_only)                done_cond = (rd_cnt_q == size_send_q);
        else if (mode_wr & ~mode_rd) done_cond = (wr_cnt_q == size_recv_q);
        else                        done_cond = (rd_cnt_q == size_send_q) &&
                                                (wr_cnt_q == size_recv_q);
    end

    // Reset is asserted asynchronously and released on a clock edge.
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) rstn_q <= 1'b0;
        else          rstn_q <= 1'b1;
    end

    always_ff @(posedge clock or negedge rstn_q) begin
        if (!rstn_q) begin
            state_q     <= StIdle;
            cfg1_q      <= '0;
            cfg3_q      <= '0;
            cfg4_q      <= '0;
            size_send_q <= '0;
            size_recv_q <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            rd_en_q     <= '0;
            wr_en_q     <= '0;
            pfr_en_q    <= 1'b0;
            pfw_en_q    <= 1'b0;
            done_q      <= 1'b0;
            ret1_q      <= '0;
            ret2_q      <= '0;
            tlb_q       <= '0;
            max_q       <= '0;
        end else if (enabled_in) begin
            if (cfg_var1 != '0) cfg1_q <= cfg_var1;
            if (cfg_var3 != '0) cfg3_q <= cfg_var3;
            if (cfg_var4 != '0) cfg4_q <= cfg_var4;
            if (cfg1_q != '0) begin
                tlb_q <= mode_dir ? (64'(TLB_SIZE) >> mode_sh) - 64'd1
                                  : (64'(TLB_SIZE) << mode_sh) - 64'd1;
                max_q <= mode_dir ? (64'(MAX_TLB_CL_REQUESTS) >> mode_sh) - 64'd1
                                  : (64'(MAX_TLB_CL_REQUESTS) << mode_sh) - 64'd1;
            end
            ret1_q <= rd_only ? 64'(rd_cnt_q) : 64'(wr_cnt_q);
            ret2_q <= rd_only ? 64'(wr_cnt_q) : 64'(rd_cnt_q);
            unique case (state_q)
                StIdle: begin
                    if (wed_valid && cfg1_q != '0) begin
                        state_q     <= StArmed;
                        size_send_q <= size_send;
                        size_recv_q <= size_recive;
                        pfr_en_q    <= mode_pfr;
                        pfw_en_q    <= mode_pfw;
                    end
                end
                StArmed, StRun: begin
                    if (!wed_valid) begin
                        // Abort: back to idle with everything quiet and no completion.
                        state_q  <= StIdle;
                        rd_cnt_q <= '0;
                        wr_cnt_q <= '0;
                        rd_en_q  <= '0;
                        wr_en_q  <= '0;
                        pfr_en_q <= 1'b0;
                        pfw_en_q <= 1'b0;
                    end else if (state_q == StArmed) begin
                        state_q  <= StRun;
                        rd_cnt_q <= '0;
                        wr_cnt_q <= '0;
                        rd_en_q  <= rd_en_d;
                        wr_en_q  <= wr_en_d;
                        pfr_en_q <= mode_pfr;
                        pfw_en_q <= mode_pfw;
                    end else begin
                        // Pulses in the completing cycle still count; saturation bounds them.
                        rd_cnt_q <= rd_cnt_d;
                        wr_cnt_q <= wr_cnt_d;
                        if (done_cond) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            rd_en_q  <= '0;
                            wr_en_q  <= '0;
                            pfr_en_q <= 1'b0;
                            pfw_en_q <= 1'b0;
                        end else begin
                            rd_en_q  <= rd_en_d;
                            wr_en_q  <= wr_en_d;
                            pfr_en_q <= mode_pfr;
                            pfw_en_q <= mode_pfw;
                        end
                    end
                end
                StDone: begin
                    if (!wed_valid) begin
                        state_q  <= StIdle;
                        done_q   <= 1'b0;
                        rd_cnt_q <= '0;
                        wr_cnt_q <= '0;
                    end
                end
            endcase
        end
    end

    assign chan_bus.chan_read_enable      = rd_en_q;
    assign chan_bus.chan_write_enable     = wr_en_q;
    assign chan_bus.prefetch_read_enable  = pfr_en_q;
    assign chan_bus.prefetch_write_enable = pfw_en_q;
    assign tlb_size               = tlb_q;
    assign max_tlb_cl_requests    = max_q;
    assign read_job_counter_done  = rd_cnt_q;
    assign write_job_counter_done = wr_cnt_q;
    assign cu_return_var1         = ret1_q;
    assign cu_return_var2         = ret2_q;
    assign cu_done                = done_q;
    assign cu_status              = {(cfg1_q != '0) && (cfg3_q != '0) && (cfg4_q != '0), 63'd0};
    assign cu_state               = state_q;
endmodule
